// File: rtl/posit_field_extract.sv
// posit_field_extract: two-stage elastic pipeline after the regime decoder.
// S1 registers the incoming triple and classifies zero/NaR; S2 forms the
// combined scale k*2^ES + exp and the hidden-bit fraction, and its registers
// drive the outputs directly. Both stages advance on a shared ready chain,
// so throughput is one word per cycle with no skid buffer.
module posit_field_extract #(
   parameter int BITS  = 16,
   parameter int ES    = 1,
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BITS-1:0]     in_posit,
   input  logic [BITS-1:0]     in_seed,
   input  logic [BITS-1:0]     in_shifted,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_sign,
   output logic [BITS-1:0]     out_scale,
   output logic [BITS-ES:0]    out_frac,
   output logic                out_zero,
   output logic                out_nar,
   output logic [CNT_W-1:0]    out_count
);

   localparam logic [BITS-1:0] NAR_WORD = {1'b1, {(BITS-1){1'b0}}};

   // Stage 1 state: only the sign of the posit is needed downstream.
   logic                s1_valid_reg;
   logic                s1_sign_reg;
   logic                s1_zero_reg;
   logic                s1_nar_reg;
   logic [BITS-1:0]     s1_seed_reg;
   logic [BITS-1:0]     s1_shifted_reg;

   // Stage 2 state doubles as the output register set.
   logic                s2_valid_reg;
   logic                s2_sign_reg;
   logic                s2_zero_reg;
   logic                s2_nar_reg;
   logic [BITS-1:0]     s2_scale_reg;
   logic [BITS-ES:0]    s2_frac_reg;
   logic [CNT_W-1:0]    count_reg;

   logic                s2_load;
   logic                s1_load;
   logic                in_fire;
   logic                out_fire;
   logic [BITS-1:0]     exp_ext;
   logic [BITS-1:0]     scale_next;
   logic [BITS-ES:0]    frac_next;

   assign s2_load  = !s2_valid_reg || out_ready;
   assign s1_load  = !s1_valid_reg || s2_load;
   assign in_ready = s1_load;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = s2_valid_reg && out_ready;

   // Exponent field sits at the top of the regime-stripped word; absent when ES is 0.
   generate
      if (ES > 0) begin : g_exp
         assign exp_ext = {{(BITS-ES){1'b0}}, s1_shifted_reg[BITS-1 -: ES]};
      end else begin : g_no_exp
         assign exp_ext = '0;
      end
   endgenerate

   // Scale and fraction for the S1 entry; special values carry zero payload.
   always_comb begin
      scale_next = (s1_seed_reg << ES) + exp_ext;
      frac_next  = {1'b1, s1_shifted_reg[BITS-ES-1:0]};
      if (s1_zero_reg || s1_nar_reg) begin
         scale_next = '0;
         frac_next  = '0;
      end
   end

   // Stage 1: capture and classify only on a real input transfer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_reg   <= 1'b0;
         s1_sign_reg    <= 1'b0;
         s1_zero_reg    <= 1'b0;
         s1_nar_reg     <= 1'b0;
         s1_seed_reg    <= '0;
         s1_shifted_reg <= '0;
      end else if (s1_load) begin
         s1_valid_reg <= in_valid;
         if (in_fire) begin
            s1_sign_reg    <= in_posit[BITS-1];
            s1_zero_reg    <= (in_posit == '0);
            s1_nar_reg     <= (in_posit == NAR_WORD);
            s1_seed_reg    <= in_seed;
            s1_shifted_reg <= in_shifted;
         end
      end
   end

   // Stage 2: outputs hold while stalled, load new results only from a valid S1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid_reg <= 1'b0;
         s2_sign_reg  <= 1'b0;
         s2_zero_reg  <= 1'b0;
         s2_nar_reg   <= 1'b0;
         s2_scale_reg <= '0;
         s2_frac_reg  <= '0;
      end else if (s2_load) begin
         s2_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            s2_sign_reg  <= s1_sign_reg;
            s2_zero_reg  <= s1_zero_reg;
            s2_nar_reg   <= s1_nar_reg;
            s2_scale_reg <= scale_next;
            s2_frac_reg  <= frac_next;
         end
      end
   end

   // Count completed output transfers, sticking at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (out_fire && (count_reg != {CNT_W{1'b1}})) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign out_valid = s2_valid_reg;
   assign out_sign  = s2_sign_reg;
   assign out_scale = s2_scale_reg;
   assign out_frac  = s2_frac_reg;
   assign out_zero  = s2_zero_reg;
   assign out_nar   = s2_nar_reg;
   assign out_count = count_reg;

endmodule
